// File: rtl/collective_pkg.sv
// Shared field layout for collective flits and communicator-table entries,
// plus the fan-out scheduler state encoding.
package collective_pkg;

    localparam int FLIT_W     = 82;
    localparam int VALID_BIT  = 81;
    localparam int DST_LSB    = 72;
    localparam int SRC_LSB    = 63;
    localparam int RANK_LSB   = 54;
    localparam int CTX_LSB    = 46;
    localparam int COORD_W    = 9;
    localparam int CTX_W      = 8;

    localparam int ENTRY_W      = 43;
    localparam int CFG_ADDR_W   = 2;
    localparam int E_FIRST_LSB  = 0;
    localparam int E_SECOND_LSB = 9;
    localparam int E_THIRD_LSB  = 18;
    localparam int E_LGCS_LSB   = 27;
    localparam int E_LGCS_W     = 4;
    localparam int E_CHILD_LSB  = 31;
    localparam int E_CHILD_W    = 3;
    localparam int E_LRANK_LSB  = 34;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [COORD_W-1:0] entry_dst(input logic [ENTRY_W-1:0] e,
                                                      input logic [1:0] k);
        case (k)
            2'd0:    return e[E_FIRST_LSB  +: COORD_W];
            2'd1:    return e[E_SECOND_LSB +: COORD_W];
            default: return e[E_THIRD_LSB  +: COORD_W];
        endcase
    endfunction

endpackage

// File: rtl/comm_table_rf.sv
// Communicator table: one registered write port, one combinational read port.
// A same-cycle write is only visible to reads from the following cycle.
module comm_table_rf
    import collective_pkg::*;
#(
    parameter int Entries = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [CFG_ADDR_W-1:0] waddr,
    input  logic [ENTRY_W-1:0]    wdata,
    input  logic [CFG_ADDR_W-1:0] raddr,
    output logic [ENTRY_W-1:0]    rdata
);

    logic [ENTRY_W-1:0] mem [Entries];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Entries; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < Entries)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < Entries) ? mem[raddr] : '0;

endmodule

// File: rtl/collective_fanout_sched.sv
// Collective fan-out scheduler: replicates an accepted flit to up to three children.
// Optional build macro FANOUT_SELF_SKIP_EN drops child beats addressed to MY_XYZ.
module collective_fanout_sched
    import collective_pkg::*;
#(
    parameter int               FlitWidth     = 82,
    parameter int               CommTableSize = 4,
    parameter logic [COORD_W-1:0] MY_XYZ      = 9'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FlitWidth-1:0]  in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  cfg_we,
    input  logic [CFG_ADDR_W-1:0] cfg_addr,
    input  logic [ENTRY_W-1:0]    cfg_data,
    output logic [FlitWidth-1:0]  out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_ctx,
    output logic [15:0]           sent_count
);

`ifdef FANOUT_SELF_SKIP_EN
    localparam bit SelfSkip = 1'b1;
`else
    localparam bit SelfSkip = 1'b0;
`endif

    localparam logic [CTX_W-1:0] CtxLimit = CTX_W'(CommTableSize);

    state_t                 state_q, state_d;
    logic [FlitWidth-1:0]   flit_q;
    logic [ENTRY_W-1:0]     entry_q;
    logic [1:0]             n_q;
    logic [1:0]             idx_q, idx_d;
    logic [ENTRY_W-1:0]     rd_data;
    logic [FlitWidth-1:0]   beat_d;
    logic                   load_beat, clr_valid, latch_pkt, err_d;
    logic                   accept, handshake, ctx_ok;
    logic [1:0]             new_n;
    logic [2:0]             first_sel, next_sel;

    function automatic logic [1:0] fanout_n(input logic [ENTRY_W-1:0] e);
        logic [E_CHILD_W-1:0] c;
        c = e[E_CHILD_LSB +: E_CHILD_W];
        return (c > 3'd3) ? 2'd3 : c[1:0];
    endfunction

    function automatic logic beat_skipped(input logic [ENTRY_W-1:0] e, input logic [1:0] k);
        return SelfSkip && (entry_dst(e, k) == MY_XYZ);
    endfunction

    // Returns {found, index} of the lowest non-skipped beat at or after 'start'.
    function automatic logic [2:0] find_beat(input logic [ENTRY_W-1:0] e,
                                             input logic [1:0] n,
                                             input logic [2:0] start);
        logic [2:0] r;
        r = '0;
        for (int k = 2; k >= 0; k--) begin
            if (k >= int'(start) && k < int'(n) && !beat_skipped(e, 2'(k))) begin
                r = {1'b1, 2'(k)};
            end
        end
        return r;
    endfunction

    function automatic logic [FlitWidth-1:0] build_beat(input logic [FlitWidth-1:0] f,
                                                        input logic [ENTRY_W-1:0]   e,
                                                        input logic [1:0]           n,
                                                        input logic [1:0]           k);
        logic [FlitWidth-1:0] r;
        r = f;
        if (n != 2'd0) begin
            r[DST_LSB  +: COORD_W] = entry_dst(e, k);
            r[RANK_LSB +: COORD_W] = e[E_LRANK_LSB +: COORD_W];
        end
        return r;
    endfunction

    comm_table_rf #(
        .Entries (CommTableSize)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (in_flit[CTX_LSB +: CFG_ADDR_W]),
        .rdata (rd_data)
    );

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid & in_ready & in_flit[VALID_BIT];
    assign handshake = out_valid & out_ready;
    assign ctx_ok    = (in_flit[CTX_LSB +: CTX_W] < CtxLimit);
    assign new_n     = fanout_n(rd_data);
    assign first_sel = find_beat(rd_data, new_n, 3'd0);
    assign next_sel  = find_beat(entry_q, n_q, {1'b0, idx_q} + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaf packets (n=0) always emit exactly one unmodified beat; self-skip only
    // applies to replicated child beats.
    always_comb begin
        state_d   = state_q;
        load_beat = 1'b0;
        clr_valid = 1'b0;
        latch_pkt = 1'b0;
        err_d     = 1'b0;
        idx_d     = idx_q;
        beat_d    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!ctx_ok) begin
                        err_d = 1'b1;
                    end else if (new_n == 2'd0) begin
                        latch_pkt = 1'b1;
                        load_beat = 1'b1;
                        idx_d     = 2'd0;
                        beat_d    = in_flit;
                        state_d   = SEND;
                    end else if (first_sel[2]) begin
                        latch_pkt = 1'b1;
                        load_beat = 1'b1;
                        idx_d     = first_sel[1:0];
                        beat_d    = build_beat(in_flit, rd_data, new_n, first_sel[1:0]);
                        state_d   = SEND;
                    end
                end
            end
            SEND: begin
                if (handshake) begin
                    if (next_sel[2]) begin
                        load_beat = 1'b1;
                        idx_d     = next_sel[1:0];
                        beat_d    = build_beat(flit_q, entry_q, n_q, next_sel[1:0]);
                    end else begin
                        clr_valid = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_flit   <= '0;
            err_ctx    <= 1'b0;
            sent_count <= '0;
            n_q        <= '0;
            idx_q      <= '0;
        end else begin
            err_ctx <= err_d;
            if (load_beat) begin
                out_valid <= 1'b1;
                out_flit  <= beat_d;
                idx_q     <= idx_d;
            end else if (clr_valid) begin
                out_valid <= 1'b0;
            end
            if (latch_pkt) begin
                n_q <= new_n;
            end
            if (handshake) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

    // Packet snapshot: later table writes must not disturb the flit in flight.
    always_ff @(posedge clk) begin
        if (latch_pkt) begin
            flit_q  <= in_flit;
            entry_q <= rd_data;
        end
    end

endmodule

// File: tb/tb_collective_fanout_sched.sv
// Directed bench for collective_fanout_sched with a queue-based reference model.
// Build with FANOUT_SELF_SKIP_EN defined to exercise the self-skip variant.
module tb_collective_fanout_sched;

    localparam logic [8:0] MY = 9'h002;
`ifdef FANOUT_SELF_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [81:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [42:0] cfg_data;
    logic [81:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic        err_ctx;
    logic [15:0] sent_count;

    collective_fanout_sched #(
        .FlitWidth     (82),
        .CommTableSize (4),
        .MY_XYZ        (MY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_ctx    (err_ctx),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [81:0] exp_q[$];
    int          exp_cnt = 0;
    logic        exp_err = 1'b0;
    logic [42:0] shadow [4];
    logic [81:0] cap_flit[$];
    int          cap_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [81:0] mk_flit(input logic v, input logic [8:0] dst, input logic [8:0] src,
                                            input logic [8:0] rank, input logic [7:0] ctx,
                                            input logic [45:0] low);
        return {v, dst, src, rank, ctx, low};
    endfunction

    function automatic logic [42:0] mk_entry(input logic [8:0] lr, input logic [2:0] ch,
                                             input logic [8:0] third, input logic [8:0] second,
                                             input logic [8:0] first);
        return {lr, ch, 4'h0, third, second, first};
    endfunction

    // Reference: every accepted packet becomes a list of expected beats.
    task automatic model_accept(input logic [81:0] f);
        logic [42:0] e;
        logic [8:0]  d [3];
        logic [81:0] b;
        int          n;
        if (!f[81]) return;
        if (f[53:46] >= 8'd4) begin
            exp_err = 1'b1;
            return;
        end
        e = shadow[f[47:46]];
        n = (e[33:31] > 3'd3) ? 3 : int'(e[33:31]);
        if (n == 0) begin
            exp_q.push_back(f);
            return;
        end
        d[0] = e[8:0];
        d[1] = e[17:9];
        d[2] = e[26:18];
        for (int k = 0; k < n; k++) begin
            if (SKIP && d[k] == MY) continue;
            b = f;
            b[80:72] = d[k];
            b[62:54] = e[42:34];
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", {81'b0, out_valid}, 82'd0);
            check("rst_out_flit", out_flit, 82'd0);
            check("rst_sent_count", {66'b0, sent_count}, 82'd0);
            check("rst_err_ctx", {81'b0, err_ctx}, 82'd0);
        end else begin
            check("in_ready", {81'b0, in_ready}, {81'b0, exp_q.size() == 0});
            check("out_valid", {81'b0, out_valid}, {81'b0, exp_q.size() != 0});
            check("sent_count", {66'b0, sent_count}, {66'b0, 16'(exp_cnt)});
            check("err_ctx", {81'b0, err_ctx}, {81'b0, exp_err});
            exp_err = 1'b0;
            if (out_valid && exp_q.size() != 0) begin
                check("out_flit", out_flit, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    exp_cnt++;
                    cap_flit.push_back(out_flit);
                    cap_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic cfg_write(input logic [1:0] a, input logic [42:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic present(input logic [81:0] f, input bit same_cfg,
                           input logic [1:0] ca, input logic [42:0] cd);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("ready_timeout", {81'b0, in_ready}, 82'd1);
        in_flit = f; in_valid = 1'b1;
        if (same_cfg) begin
            cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(f);
        if (same_cfg) begin
            cfg_we = 1'b0;
            shadow[ca] = cd;
        end
    endtask

    task automatic drain(input logic [7:0] pat, input int plen, input bit mid_cfg,
                         input logic [1:0] ca, input logic [42:0] cd);
        int t = 0;
        for (int i = 0; i < plen; i++) begin
            out_ready = pat[i];
            if (i == 0 && mid_cfg) begin
                cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
            end
            @(posedge clk); #1;
            if (i == 0 && mid_cfg) begin
                cfg_we = 1'b0;
                shadow[ca] = cd;
            end
        end
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 64) begin
            @(posedge clk); #1; t++;
        end
        check("drain_timeout", {81'b0, exp_q.size() == 0}, 82'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_pkt(input logic [81:0] f);
        cap_flit.delete(); cap_cyc.delete();
        present(f, 1'b0, 2'd0, 43'd0);
        drain(8'h00, 0, 1'b0, 2'd0, 43'd0);
    endtask

    localparam int N3 = SKIP ? 2 : 3;

    logic [42:0] e_orig, e_alt;
    logic [81:0] f0, f1, f2, fbad, fnv;

    initial begin
        rst_n = 1'b0; in_flit = '0; in_valid = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) shadow[i] = '0;
        e_orig = mk_entry(9'h000, 3'd3, 9'h004, 9'h002, 9'h001);
        e_alt  = mk_entry(9'h007, 3'd2, 9'h00C, 9'h00B, 9'h00A);
        f0   = mk_flit(1'b1, 9'h1FF, 9'h033, 9'h0AB, 8'd0, 46'h0123456789AB);
        f1   = mk_flit(1'b1, 9'h0F0, 9'h011, 9'h0CD, 8'd1, 46'h2AAAAAAAAAAA);
        f2   = mk_flit(1'b1, 9'h155, 9'h0EE, 9'h012, 8'd2, 46'h15555555555);
        fbad = mk_flit(1'b1, 9'h001, 9'h002, 9'h003, 8'd5, 46'h3);
        fnv  = mk_flit(1'b0, 9'h001, 9'h002, 9'h003, 8'd0, 46'h4);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        cfg_write(2'd0, e_orig);
        cfg_write(2'd1, mk_entry(9'h055, 3'd0, 9'h0, 9'h0, 9'h0));
        cfg_write(2'd2, mk_entry(9'h01A, 3'd5, 9'h030, 9'h020, 9'h010));
        cfg_write(2'd3, mk_entry(9'h066, 3'd1, 9'h000, 9'h000, 9'h002));

        // three-way fan-out, consecutive beats
        run_pkt(f0);
        check("fan3_count", cap_flit.size(), N3);
        check("fan3_dst0", {73'b0, cap_flit[0][80:72]}, 82'h001);
        check("fan3_dst_last", {73'b0, cap_flit[N3-1][80:72]}, 82'h004);
        if (!SKIP) check("fan3_dst1", {73'b0, cap_flit[1][80:72]}, 82'h002);
        check("fan3_rank", {73'b0, cap_flit[0][62:54]}, 82'h000);
        check("fan3_src", {73'b0, cap_flit[0][71:63]}, 82'h033);
        check("fan3_low", {28'b0, cap_flit[0][53:0]}, {28'b0, f0[53:0]});
        check("fan3_consecutive", cap_cyc[N3-1] - cap_cyc[0], N3 - 1);

        // stalled downstream: 1,0,0,1,1
        cap_flit.delete(); cap_cyc.delete();
        present(f0, 1'b0, 2'd0, 43'd0);
        drain(8'b11001, 5, 1'b0, 2'd0, 43'd0);
        check("stall_count", cap_flit.size(), N3);
        check("stall_gap", cap_cyc[1] - cap_cyc[0], 3);
        check("stall_sent_count", {66'b0, sent_count}, SKIP ? 82'd4 : 82'd6);

        // bad context and invalid flit
        run_pkt(fbad);
        check("badctx_no_beats", cap_flit.size(), 0);
        run_pkt(fnv);
        check("novalid_no_beats", cap_flit.size(), 0);

        // leaf
        run_pkt(f1);
        check("leaf_count", cap_flit.size(), 1);
        check("leaf_bits", cap_flit[0], f1);

        // children clamp to three
        run_pkt(f2);
        check("clamp_count", cap_flit.size(), 3);
        check("clamp_dst2", {73'b0, cap_flit[2][80:72]}, 82'h030);
        check("clamp_rank", {73'b0, cap_flit[1][62:54]}, 82'h01A);

        // table write during flight leaves packet intact
        cap_flit.delete(); cap_cyc.delete();
        present(f0, 1'b0, 2'd0, 43'd0);
        drain(8'b0, 1, 1'b1, 2'd0, e_alt);
        check("midcfg_count", cap_flit.size(), N3);
        check("midcfg_dst0", {73'b0, cap_flit[0][80:72]}, 82'h001);

        // same-cycle write and accept: old entry (e_alt) used
        cap_flit.delete(); cap_cyc.delete();
        present(f0, 1'b1, 2'd0, e_orig);
        drain(8'h00, 0, 1'b0, 2'd0, 43'd0);
        check("samecfg_count", cap_flit.size(), 2);
        check("samecfg_dst1", {73'b0, cap_flit[1][80:72]}, 82'h00B);
        check("samecfg_rank", {73'b0, cap_flit[0][62:54]}, 82'h007);

        // single child addressed to self
        run_pkt(mk_flit(1'b1, 9'h100, 9'h001, 9'h001, 8'd3, 46'h7));
        check("selfchild_count", cap_flit.size(), SKIP ? 0 : 1);

        // reset in the middle of a fan-out
        cap_flit.delete(); cap_cyc.delete();
        present(f0, 1'b0, 2'd0, 43'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete(); exp_cnt = 0; exp_err = 1'b0;
        for (int i = 0; i < 4; i++) shadow[i] = '0;
        #1;
        check("abort_out_valid", {81'b0, out_valid}, 82'd0);
        check("abort_sent_count", {66'b0, sent_count}, 82'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_beats", cap_flit.size(), 1);

        // table cleared by reset: entry 0 now a leaf
        run_pkt(f0);
        check("post_rst_count", cap_flit.size(), 1);
        check("post_rst_bits", cap_flit[0], f0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
